nnrv_mem: RTL and testbench

//  Memory stage of the nnrv pipeline. Consumes the rd/ram request bundle registered by the exec stage.

---
 rtl/nnrv_mem_pkg.sv | 19 +
 rtl/nnrv_mem_load_align.sv | 37 +++
 rtl/nnrv_mem.sv | 161 ++++++++++++++++
 tb/tb_nnrv_mem.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nnrv_mem_pkg.sv
// nnrv_mem_pkg: shared types and constants for the nnrv memory stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: datapath width, memory-stage FSM state type, canonical byte-lane masks.
package nnrv_mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_BUS  = 1'b1
    } mem_state_t;

    // Lane masks after normalisation to lane 0 (mask >> addr[1:0]).
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/nnrv_mem_load_align.sv
// nnrv_mem_load_align: shifts bus read data down to lane 0 and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: i_rdata (bus word), i_addr_lo (byte offset), i_mask (lane mask, pre-shifted),
//        i_sign (sign-extend enable), o_data (aligned result).
module nnrv_mem_load_align
    import nnrv_mem_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_addr_lo,
    input  logic [3:0]      i_mask,
    input  logic            i_sign,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_raw;
    logic [3:0]      w_m;

    assign w_raw = i_rdata >> {i_addr_lo, 3'b000};
    assign w_m   = i_mask >> i_addr_lo;

    always_comb begin
        o_data = '0;
        case (w_m)
            MASK_B:  o_data = {{24{i_sign & w_raw[7]}}, w_raw[7:0]};
            MASK_H:  o_data = {{16{i_sign & w_raw[15]}}, w_raw[15:0]};
            MASK_W:  o_data = w_raw;
            // Irregular masks: keep only the enabled bytes, never extend.
            default: begin
                for (int i = 0; i < 4; i++) begin
                    o_data[8*i +: 8] = w_m[i] ? w_raw[8*i +: 8] : 8'h00;
                end
            end
        endcase
    end

endmodule

// File: rtl/nnrv_mem.sv
// nnrv_mem: memory stage -- runs load/store bus transactions and registers the writeback result.
// Latency: non-memory ops 1 cycle; loads/stores 2 cycles minimum (request edge + ack edge).
// Backpressure: o_stall holds exec/id from request until the cycle the bus acks.
// Ports: i_clk/i_rst (sync, active-high); i_ex_* request bundle from exec; o_dbus_*/i_dbus_*
//        req/ack data bus; o_wb_* writeback to regfile/forwarding; o_stall upstream hold.
// Option: define NNRV_MEM_MISALIGN_EN to add o_misalign and suppress misaligned half/word accesses.
module nnrv_mem
    import nnrv_mem_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_rd_en,
    input  logic [4:0]      i_ex_rd,
    input  logic [XLEN-1:0] i_ex_rd_reg,
    input  logic            i_ex_ram_rd_en,
    input  logic            i_ex_ram_wr_en,
    input  logic [XLEN-1:0] i_ex_ram_addr,
    input  logic [XLEN-1:0] i_ex_ram_data,
    input  logic [3:0]      i_ex_ram_mask,
    input  logic            i_ex_sign,
    output logic            o_stall,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [XLEN-1:0] o_dbus_addr,
    output logic [XLEN-1:0] o_dbus_wdata,
    output logic [3:0]      o_dbus_mask,
    input  logic            i_dbus_ack,
    input  logic [XLEN-1:0] i_dbus_rdata,
`ifdef NNRV_MEM_MISALIGN_EN
    output logic            o_misalign,
`endif
    output logic            o_wb_rd_en,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_rd_reg
);

    mem_state_t      r_state;
    logic            r_req;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_mask;
    logic [1:0]      r_addr_lo;
    logic            r_sign;
    logic            r_rd_en;
    logic [4:0]      r_rd;
    logic            r_wb_rd_en;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_rd_reg;

    logic            w_memop;
    logic            w_misalign;
    logic            w_start;
    logic [XLEN-1:0] w_load_data;

    assign w_memop = i_ex_ram_rd_en | i_ex_ram_wr_en;

`ifdef NNRV_MEM_MISALIGN_EN
    logic            r_misalign;
    logic [3:0]      w_m;
    logic            w_is_word;
    logic            w_is_half;

    // Access size is inferred from the lane-0 normalised mask: any lane above 1 means word.
    assign w_m        = i_ex_ram_mask >> i_ex_ram_addr[1:0];
    assign w_is_word  = |w_m[3:2];
    assign w_is_half  = w_m[1] & ~w_is_word;
    assign w_misalign = w_memop & ((w_is_word & |i_ex_ram_addr[1:0]) |
                                   (w_is_half & i_ex_ram_addr[0]));
    assign o_misalign = r_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start = (r_state == MEM_IDLE) & w_memop & ~w_misalign;
    assign o_stall = w_start | ((r_state == MEM_BUS) & ~i_dbus_ack);

    nnrv_mem_load_align u_align (
        .i_rdata   (i_dbus_rdata),
        .i_addr_lo (r_addr_lo),
        .i_mask    (r_mask),
        .i_sign    (r_sign),
        .o_data    (w_load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= MEM_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_addr_lo   <= '0;
            r_sign      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd        <= '0;
            r_wb_rd_en  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_rd_reg <= '0;
`ifdef NNRV_MEM_MISALIGN_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
`ifdef NNRV_MEM_MISALIGN_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                MEM_IDLE: begin
                    if (w_start) begin
                        r_state    <= MEM_BUS;
                        r_req      <= 1'b1;
                        // Store wins when both enables are set.
                        r_we       <= i_ex_ram_wr_en;
                        r_addr     <= {i_ex_ram_addr[XLEN-1:2], 2'b00};
                        r_wdata    <= i_ex_ram_data;
                        r_mask     <= i_ex_ram_mask;
                        r_addr_lo  <= i_ex_ram_addr[1:0];
                        r_sign     <= i_ex_sign;
                        r_rd_en    <= i_ex_rd_en;
                        r_rd       <= i_ex_rd;
                        r_wb_rd_en <= 1'b0;
                    end else if (w_memop) begin
                        // Only reachable for a rejected misaligned access.
                        r_wb_rd_en <= 1'b0;
`ifdef NNRV_MEM_MISALIGN_EN
                        r_misalign <= 1'b1;
`endif
                    end else begin
                        r_wb_rd_en  <= i_ex_rd_en;
                        r_wb_rd     <= i_ex_rd;
                        r_wb_rd_reg <= i_ex_rd_reg;
                    end
                end
                MEM_BUS: begin
                    r_wb_rd_en <= 1'b0;
                    if (i_dbus_ack) begin
                        r_state    <= MEM_IDLE;
                        r_req      <= 1'b0;
                        r_wb_rd_en <= r_rd_en & ~r_we;
                        r_wb_rd    <= r_rd;
                        if (!r_we) begin
                            r_wb_rd_reg <= w_load_data;
                        end
                    end
                end
                default: r_state <= MEM_IDLE;
            endcase
        end
    end

    assign o_dbus_req   = r_req;
    assign o_dbus_we    = r_we;
    assign o_dbus_addr  = r_addr;
    assign o_dbus_wdata = r_wdata;
    assign o_dbus_mask  = r_mask;
    assign o_wb_rd_en   = r_wb_rd_en;
    assign o_wb_rd      = r_wb_rd;
    assign o_wb_rd_reg  = r_wb_rd_reg;

endmodule

// File: tb/tb_nnrv_mem.sv
// tb_nnrv_mem: directed plus randomized checks of the nnrv memory stage against a reference model.
// Latency: n/a (bench).
// Backpressure: the bench plays the bus slave and holds its requests stable while o_stall is high.
module tb_nnrv_mem;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ex_rd_en;
    logic [4:0]  i_ex_rd;
    logic [31:0] i_ex_rd_reg;
    logic        i_ex_ram_rd_en;
    logic        i_ex_ram_wr_en;
    logic [31:0] i_ex_ram_addr;
    logic [31:0] i_ex_ram_data;
    logic [3:0]  i_ex_ram_mask;
    logic        i_ex_sign;
    logic        o_stall;
    logic        o_dbus_req;
    logic        o_dbus_we;
    logic [31:0] o_dbus_addr;
    logic [31:0] o_dbus_wdata;
    logic [3:0]  o_dbus_mask;
    logic        i_dbus_ack;
    logic [31:0] i_dbus_rdata;
`ifdef NNRV_MEM_MISALIGN_EN
    logic        o_misalign;
`endif
    logic        o_wb_rd_en;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_rd_reg;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    nnrv_mem dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ex_rd_en     (i_ex_rd_en),
        .i_ex_rd        (i_ex_rd),
        .i_ex_rd_reg    (i_ex_rd_reg),
        .i_ex_ram_rd_en (i_ex_ram_rd_en),
        .i_ex_ram_wr_en (i_ex_ram_wr_en),
        .i_ex_ram_addr  (i_ex_ram_addr),
        .i_ex_ram_data  (i_ex_ram_data),
        .i_ex_ram_mask  (i_ex_ram_mask),
        .i_ex_sign      (i_ex_sign),
        .o_stall        (o_stall),
        .o_dbus_req     (o_dbus_req),
        .o_dbus_we      (o_dbus_we),
        .o_dbus_addr    (o_dbus_addr),
        .o_dbus_wdata   (o_dbus_wdata),
        .o_dbus_mask    (o_dbus_mask),
        .i_dbus_ack     (i_dbus_ack),
        .i_dbus_rdata   (i_dbus_rdata),
`ifdef NNRV_MEM_MISALIGN_EN
        .o_misalign     (o_misalign),
`endif
        .o_wb_rd_en     (o_wb_rd_en),
        .o_wb_rd        (o_wb_rd),
        .o_wb_rd_reg    (o_wb_rd_reg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load result from the bus word, computed arithmetically from the lane rules.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [3:0] mask, input logic sign);
        longint unsigned raw;
        longint          v;
        int              sh;
        int              m;
        sh  = int'(addr % 4);
        raw = longint'(rdata) >> (8 * sh);
        m   = int'(mask) >> sh;
        if (m == 1) begin
            v = longint'(raw % 256);
            if (sign && v >= 128) v = v - 256;
        end else if (m == 3) begin
            v = longint'(raw % 65536);
            if (sign && v >= 32768) v = v - 65536;
        end else if (m == 15) begin
            v = longint'(raw);
        end else begin
            v = 0;
            for (int i = 0; i < 4; i++)
                if (((m >> i) & 1) == 1) v = v + longint'(((raw >> (8 * i)) % 256) << (8 * i));
        end
        return v[31:0];
    endfunction

    task automatic clear_ex();
        i_ex_rd_en     = 1'b0;
        i_ex_rd        = '0;
        i_ex_rd_reg    = '0;
        i_ex_ram_rd_en = 1'b0;
        i_ex_ram_wr_en = 1'b0;
        i_ex_ram_addr  = '0;
        i_ex_ram_data  = '0;
        i_ex_ram_mask  = '0;
        i_ex_sign      = 1'b0;
    endtask

    task automatic alu_op(input logic en, input logic [4:0] rd, input logic [31:0] val);
        @(negedge i_clk);
        clear_ex();
        i_ex_rd_en  = en;
        i_ex_rd     = rd;
        i_ex_rd_reg = val;
        #1 check("alu_stall", 32'(o_stall), 32'(0));
        @(posedge i_clk);
        #1;
        check("alu_wb_en", 32'(o_wb_rd_en), 32'(en));
        if (en) begin
            check("alu_wb_rd", 32'(o_wb_rd), 32'(rd));
            check("alu_wb_reg", o_wb_rd_reg, val);
        end
        check("alu_no_req", 32'(o_dbus_req), 32'(0));
    endtask

    // Issues one bus op; the bench slave acks in BUS cycle index ack_dly (0 = first).
    task automatic mem_op(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask, input logic sign,
                          input logic rd_en, input logic [4:0] rd, input int ack_dly,
                          input logic [31:0] rdata, output int stall_cycles);
        logic is_load;
        is_load = ld & ~st;
        @(negedge i_clk);
        clear_ex();
        i_ex_rd_en     = rd_en;
        i_ex_rd        = rd;
        i_ex_rd_reg    = $urandom;
        i_ex_ram_rd_en = ld;
        i_ex_ram_wr_en = st;
        i_ex_ram_addr  = addr;
        i_ex_ram_data  = data;
        i_ex_ram_mask  = mask;
        i_ex_sign      = sign;
        i_dbus_ack     = 1'b0;
        #1 check("stall_on_request", 32'(o_stall), 32'(1));
        stall_cycles = 1;
        @(posedge i_clk);
        for (int k = 0; k <= ack_dly; k++) begin
            @(negedge i_clk);
            check("bus_req", 32'(o_dbus_req), 32'(1));
            check("bus_we", 32'(o_dbus_we), 32'(st));
            check("bus_addr", o_dbus_addr, {addr[31:2], 2'b00});
            if (st) check("bus_wdata", o_dbus_wdata, data);
            check("bus_mask", 32'(o_dbus_mask), 32'(mask));
            check("bus_wb_quiet", 32'(o_wb_rd_en), 32'(0));
            if (k == ack_dly) begin
                i_dbus_ack   = 1'b1;
                i_dbus_rdata = rdata;
                #1 check("stall_drop_on_ack", 32'(o_stall), 32'(0));
            end else begin
                i_dbus_rdata = $urandom;
                #1 check("stall_while_wait", 32'(o_stall), 32'(1));
                stall_cycles++;
            end
            @(posedge i_clk);
        end
        #1;
        i_dbus_ack = 1'b0;
        clear_ex();
        check("req_after_ack", 32'(o_dbus_req), 32'(0));
        check("wb_en_after_ack", 32'(o_wb_rd_en), 32'(is_load & rd_en));
        if (is_load && rd_en) begin
            check("wb_rd_after_ack", 32'(o_wb_rd), 32'(rd));
            check("wb_load_value", o_wb_rd_reg, model_load(rdata, addr, mask, sign));
        end
    endtask

    initial begin
        int sc;
        int kind;
        int sz;
        logic [31:0] a;
        logic [3:0]  mk;
        logic [3:0]  base_mk;

        i_rst        = 1'b1;
        i_dbus_ack   = 1'b0;
        i_dbus_rdata = '0;
        clear_ex();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_stall", 32'(o_stall), 32'(0));
        check("rst_req", 32'(o_dbus_req), 32'(0));
        check("rst_we", 32'(o_dbus_we), 32'(0));
        check("rst_addr", o_dbus_addr, 32'(0));
        check("rst_wdata", o_dbus_wdata, 32'(0));
        check("rst_mask", 32'(o_dbus_mask), 32'(0));
        check("rst_wb_en", 32'(o_wb_rd_en), 32'(0));
        check("rst_wb_rd", 32'(o_wb_rd), 32'(0));
        check("rst_wb_reg", o_wb_rd_reg, 32'(0));
        @(negedge i_clk);
        i_rst = 1'b0;

        // ALU pass-through
        alu_op(1'b1, 5'd5, 32'h0000_1234);

        // LB signed, ack in third BUS cycle
        mem_op(1'b1, 1'b0, 32'h103, 32'h0, 4'b1000, 1'b1, 1'b1, 5'd7, 2, 32'h8012_3456, sc);
        check("lb_value_const", o_wb_rd_reg, 32'hFFFF_FF80);
        check("lb_stall_cycles", 32'(sc), 32'(3));

        // LHU, immediate ack
        mem_op(1'b1, 1'b0, 32'h102, 32'h0, 4'b1100, 1'b0, 1'b1, 5'd8, 0, 32'hBEEF_0000, sc);
        check("lhu_value_const", o_wb_rd_reg, 32'h0000_BEEF);
        check("lhu_stall_cycles", 32'(sc), 32'(1));

        // SW with rd_en set: writeback must stay off
        mem_op(1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b1, 5'd9, 2, 32'h0, sc);

        // Both enables set behaves as store
        mem_op(1'b1, 1'b1, 32'h344, 32'h1122_3344, 4'b1111, 1'b0, 1'b1, 5'd10, 1, 32'h5555_AAAA, sc);

        // Empty-mask store still issues a bus cycle
        mem_op(1'b0, 1'b1, 32'h408, 32'h0BAD_0BAD, 4'b0000, 1'b0, 1'b0, 5'd0, 0, 32'h0, sc);

        // Reset while a load is outstanding, then a late ack
        @(negedge i_clk);
        clear_ex();
        i_ex_rd_en     = 1'b1;
        i_ex_rd        = 5'd11;
        i_ex_ram_rd_en = 1'b1;
        i_ex_ram_addr  = 32'h300;
        i_ex_ram_mask  = 4'b1111;
        @(posedge i_clk);
        @(negedge i_clk);
        check("rstbus_req_before", 32'(o_dbus_req), 32'(1));
        i_rst = 1'b1;
        clear_ex();
        @(posedge i_clk);
        #1;
        check("rstbus_req_dropped", 32'(o_dbus_req), 32'(0));
        check("rstbus_stall", 32'(o_stall), 32'(0));
        @(negedge i_clk);
        i_rst        = 1'b0;
        i_dbus_ack   = 1'b1;
        i_dbus_rdata = 32'hDEAD_BEEF;
        @(posedge i_clk);
        #1;
        check("late_ack_no_wb", 32'(o_wb_rd_en), 32'(0));
        check("late_ack_no_req", 32'(o_dbus_req), 32'(0));
        i_dbus_ack = 1'b0;
        alu_op(1'b1, 5'd3, 32'h0000_00A5);

        // Misaligned LW at 0x101
`ifdef NNRV_MEM_MISALIGN_EN
        @(negedge i_clk);
        clear_ex();
        i_ex_rd_en     = 1'b1;
        i_ex_rd        = 5'd12;
        i_ex_ram_rd_en = 1'b1;
        i_ex_ram_addr  = 32'h101;
        i_ex_ram_mask  = 4'b1110;
        #1 check("mis_no_stall", 32'(o_stall), 32'(0));
        @(posedge i_clk);
        #1;
        check("mis_pulse", 32'(o_misalign), 32'(1));
        check("mis_no_req", 32'(o_dbus_req), 32'(0));
        check("mis_no_wb", 32'(o_wb_rd_en), 32'(0));
        clear_ex();
        @(posedge i_clk);
        #1 check("mis_pulse_end", 32'(o_misalign), 32'(0));
`else
        mem_op(1'b1, 1'b0, 32'h101, 32'h0, 4'b1110, 1'b1, 1'b1, 5'd12, 1, 32'h89AB_CDEF, sc);
        check("mis_off_value", o_wb_rd_reg, 32'h0089_ABCD);
`endif

        // Randomized mix of ALU ops and naturally aligned loads/stores
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                alu_op(1'($urandom), 5'($urandom), $urandom);
            end else begin
                sz = int'($urandom_range(0, 2));
                a  = $urandom;
                a  = a & ~((32'd1 << sz) - 32'd1);
                base_mk = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
                mk = base_mk << a[1:0];
                mem_op(kind == 1, kind == 2, a, $urandom, mk, 1'($urandom), 1'($urandom),
                       5'($urandom), int'($urandom_range(0, 3)), $urandom, sc);
            end
        end

        repeat (2) @(posedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
